// File: rtl/pipe_pkg.sv
// pipe_pkg: control-bundle types and widths shared by the pipeline boundary stages
package pipe_pkg;
  localparam int CTRL_MW_W = 3;
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_mw_t;
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ctrl_em_t;
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_ctrl;
    logic       alu_src;
  } ctrl_de_t;
  localparam int CTRL_EM_W = $bits(ctrl_em_t);
  localparam int CTRL_DE_W = $bits(ctrl_de_t);
  localparam ctrl_mw_t CTRL_MW_NOP = '0;
  localparam ctrl_em_t CTRL_EM_NOP = '0;
  localparam ctrl_de_t CTRL_DE_NOP = '0;
endpackage

// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage: valid/ready control-bundle pipeline stage with optional skid buffer and stall counter
module pipe_ctrl_stage import pipe_pkg::*; #(
  parameter int               WIDTH     = CTRL_MW_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);
  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             in_fire;
  logic             out_fire;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;
  // main_d is forced to RESET_VAL whenever main_v drops, so no output mux is needed
  generate
    if (SKID) begin : g_skid
      logic             skid_v;
      logic [WIDTH-1:0] skid_d;
      assign in_ready = !skid_v;
      always_ff @(posedge clk)
        if (reset || flush) begin
          main_v <= 1'b0;
          main_d <= RESET_VAL;
          skid_v <= 1'b0;
          skid_d <= RESET_VAL;
        end else if (out_fire && skid_v) begin
          main_d <= skid_d;
          skid_v <= 1'b0;
          skid_d <= RESET_VAL;
        end else if (in_fire && (!main_v || out_fire)) begin
          main_v <= 1'b1;
          main_d <= in_data;
        end else if (in_fire) begin
          skid_v <= 1'b1;
          skid_d <= in_data;
        end else if (out_fire) begin
          main_v <= 1'b0;
          main_d <= RESET_VAL;
        end
      a_skid_needs_main: assert property (@(posedge clk) disable iff (reset) !(skid_v && !main_v));
      a_no_triple: assert property (@(posedge clk) disable iff (reset) !(out_fire && skid_v && in_fire));
    end else begin : g_single
      assign in_ready = !main_v || out_ready;
      always_ff @(posedge clk)
        if (reset || flush) begin
          main_v <= 1'b0;
          main_d <= RESET_VAL;
        end else if (in_fire) begin
          main_v <= 1'b1;
          main_d <= in_data;
        end else if (out_fire) begin
          main_v <= 1'b0;
          main_d <= RESET_VAL;
        end
    end
  endgenerate
  always_ff @(posedge clk)
    if (reset) stall_cnt <= '0;
    else if (main_v && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  a_idle_data: assert property (@(posedge clk) disable iff (reset) !out_valid |-> out_data == RESET_VAL);
  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    out_valid && !out_ready && !flush |=> $stable(out_data));
endmodule
